// File: rtl/fetch_ifid_stage_pkg.sv
// Shared fetch/IF-ID definitions: halt FSM state encoding, NOP, PC step, IF/ID record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_ifid_stage_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fsm_state_t;

    // addi x0, x0, 0 -- also used by ID/EX and the hazard unit for bubbles
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_INC   = 32'd4;

    // Drain counter width; covers DRAIN_CYCLES up to 15
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] add_pc;
        logic [31:0] inst;
        logic        vld;
    } ifid_t;

    function automatic ifid_t ifid_bubble();
        ifid_t b;
        b.pc     = 32'd0;
        b.add_pc = 32'd0;
        b.inst   = NOP_INST;
        b.vld    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_ifid_stage_halt_drain_fsm.sv
// Halt-drain FSM: accepts a decoded halt, waits DRAIN_CYCLES edges, then raises HALT.
// Latency: HALT rises exactly DRAIN_CYCLES edges after acceptance when no stall intervenes.
// Backpressure: STALL freezes the drain counter; FLUSH in DRAIN cancels the halt.
// Ports: CLK/RSTn; stall, flush, halt_req, valid_ifid in; state, halt (registered),
//        halt_acc (combinational acceptance strobe) out.
module halt_drain_fsm
    import fetch_ifid_stage_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       stall,
    input  logic       flush,
    input  logic       halt_req,
    input  logic       valid_ifid,
    output fsm_state_t state,
    output logic       halt,
    output logic       halt_acc
);

    logic [CNT_W-1:0] drain_cnt;

    // A halt only counts when it sits in a live IF/ID slot and nothing outranks it
    assign halt_acc = (state == ST_RUN) && halt_req && valid_ifid && !flush && !stall;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halt      <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_acc) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    // An older branch resolving in EX squashes the halt itself
                    if (flush) begin
                        state     <= ST_RUN;
                        drain_cnt <= '0;
                    end else if (!stall) begin
                        if (drain_cnt == '0) begin
                            state <= ST_HALTED;
                            halt  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_HALTED: begin
                    // terminal until reset
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_ifid_stage.sv
// Instruction fetch + IF/ID register: owns the PC, drives IMEM, latches PC/PC+4/inst.
// Latency: fetch to IF/ID output is 1 cycle; IMEM read is combinational on I_MEM_ADDR.
// Backpressure: STALL holds PC and IF/ID; FLUSH redirects and bubbles; halt drains then stops.
// Ports: CLK, RSTn; I_MEM_DI/I_MEM_ADDR/I_MEM_CSN to IMEM; STALL, FLUSH, REDIRECT_PC,
//        HALT_REQ control in; PC_IFID, ADD_PC_IFID, INST_IFID, VALID_IFID, HALT out.
// Optional: define FETCH_CNT_EN to add FETCH_CNT, a count of normal fetches.
module fetch_ifid_stage
    import fetch_ifid_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_AW      = 12,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [31:0]        I_MEM_DI,
    input  logic               STALL,
    input  logic               FLUSH,
    input  logic [31:0]        REDIRECT_PC,
    input  logic               HALT_REQ,
    output logic [IMEM_AW-1:0] I_MEM_ADDR,
    output logic               I_MEM_CSN,
    output logic [31:0]        PC_IFID,
    output logic [31:0]        ADD_PC_IFID,
    output logic [31:0]        INST_IFID,
    output logic               VALID_IFID,
    output logic               HALT
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0]        FETCH_CNT
`endif
);

    fsm_state_t  state;
    logic        halt_acc;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    ifid_t       ifid;
    logic        do_fetch;

    halt_drain_fsm #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_halt_drain_fsm (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .stall      (STALL),
        .flush      (FLUSH),
        .halt_req   (HALT_REQ),
        .valid_ifid (ifid.vld),
        .state      (state),
        .halt       (HALT),
        .halt_acc   (halt_acc)
    );

    assign pc_next_seq = pc + PC_INC;   // wraps modulo 2^32
    assign do_fetch    = (state == ST_RUN) && !FLUSH && !STALL && !halt_acc;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pc   <= RESET_PC;
            ifid <= ifid_bubble();
        end else begin
            case (state)
                ST_RUN: begin
                    if (FLUSH) begin
                        pc   <= REDIRECT_PC;
                        ifid <= ifid_bubble();
                    end else if (STALL) begin
                        // hold PC and IF/ID
                    end else if (halt_acc) begin
                        // PC stays on the instruction after the halt
                        ifid <= ifid_bubble();
                    end else begin
                        ifid.pc     <= pc;
                        ifid.add_pc <= pc_next_seq;
                        ifid.inst   <= I_MEM_DI;
                        ifid.vld    <= 1'b1;
                        pc          <= pc_next_seq;
                    end
                end
                ST_DRAIN: begin
                    // IF/ID is already a bubble from the acceptance edge
                    if (FLUSH) begin
                        pc <= REDIRECT_PC;
                    end
                end
                default: begin
                    // HALTED: everything frozen
                end
            endcase
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fetch_cnt <= 32'd0;
        end else if (do_fetch) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign FETCH_CNT = fetch_cnt;
`else
    logic unused_fetch;
    assign unused_fetch = do_fetch;
`endif

    assign I_MEM_ADDR  = pc[IMEM_AW-1:0];
    assign I_MEM_CSN   = (state != ST_RUN);
    assign PC_IFID     = ifid.pc;
    assign ADD_PC_IFID = ifid.add_pc;
    assign INST_IFID   = ifid.inst;
    assign VALID_IFID  = ifid.vld;

endmodule
